// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS RAM reader: FSM state encoding,
// drain length, and the phase-to-table-address mapping.
package dds_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dds_state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_CNT_W  = 2;

  // The table is addressed by the most significant addr_w bits of the phase.
  function automatic logic [63:0] phase_to_addr(input logic [63:0] phase,
                                                input int phase_w,
                                                input int addr_w);
    return phase >> (phase_w - addr_w);
  endfunction

endpackage

// File: rtl/dds_ram_reader_sp_ram.sv
// Inferred single-port block RAM with a one-cycle registered read.
// Port names match blk_mem_gen_0 so the vendor IP can be dropped in.
module sp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clka,
  input  logic [0:0]        wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Read-first port: douta always carries the word stored before this edge.
  always_ff @(posedge clka) begin
    if (wea[0]) begin
      mem[addra] <= dina;
    end
    douta <= mem[addra];
  end

endmodule

// File: rtl/dds_ram_reader.sv
// Phase-accumulator waveform generator. In IDLE the table is loaded through
// the valid/ready write port; in RUN the RAM is read once per clock at the
// address given by the top bits of (acc + pword); DRAIN lets the pipeline
// empty before the write port is handed back.
module dds_ram_reader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               en,
  input  logic [PHASE_W-1:0] fword,
  input  logic [PHASE_W-1:0] pword,
  output logic               dout_valid,
  output logic [DATA_W-1:0]  dout,
  output logic               busy
);

  import dds_pkg::*;

  dds_state_t               state;
  dds_state_t               state_next;
  logic [DRAIN_CNT_W-1:0]   drain_cnt;
  logic [PHASE_W-1:0]       acc;
  logic [PHASE_W-1:0]       phase_sum;
  logic [ADDR_W-1:0]        run_addr;
  logic                     rd_v1;
  logic [0:0]               wea;
  logic [ADDR_W-1:0]        addra;
  logic [DATA_W-1:0]        dina;
  logic [DATA_W-1:0]        douta;

  assign phase_sum = acc + pword;
  assign run_addr  = ADDR_W'(phase_to_addr(64'(phase_sum), PHASE_W, ADDR_W));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a pending write in IDLE takes priority over starting a run.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && !load_valid) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: the loader owns the RAM port only in IDLE.
  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state == RUN) || (state == DRAIN);
    wea        = 1'(load_ready && load_valid);
    addra      = load_ready ? load_addr : run_addr;
    dina       = load_data;
  end

  // Counts edges spent in DRAIN; cleared whenever we are elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Phase accumulation and the two-stage read-valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      rd_v1      <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      if (state == RUN) begin
        acc <= acc + fword;
      end else begin
        acc <= '0;
      end
      rd_v1      <= (state == RUN) && en;
      dout_valid <= rd_v1;
      if (rd_v1) begin
        dout <= douta;
      end
    end
  end

  sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clka (clk),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .douta(douta)
  );

endmodule

// File: tb/tb_dds_ram_reader.sv
// Self-checking bench for dds_ram_reader: directed scenarios plus random
// runs, all checked against a behavioural table/phase model.
module tb_dds_ram_reader;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        en;
  logic [31:0] fword;
  logic [31:0] pword;
  logic        dout_valid;
  logic [31:0] dout;
  logic        busy;

  int          total;
  int          bad;
  logic [31:0] model_tbl [0:1023];

  dds_ram_reader #(
    .ADDR_W (10),
    .DATA_W (32),
    .PHASE_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_addr (load_addr),
    .load_data (load_data),
    .en        (en),
    .fword     (fword),
    .pword     (pword),
    .dout_valid(dout_valid),
    .dout      (dout),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sample n: table entry at the top 10 bits of n*fword + pword.
  function automatic logic [31:0] modelSample(input int n, input logic [31:0] fw, input logic [31:0] pw);
    logic [31:0] ph;
    ph = 32'(n) * fw + pw;
    return model_tbl[int'(ph >> 22)];
  endfunction

  task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data);
    checkOutput("load_ready_before_write", 64'(load_ready), 64'd1);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
    model_tbl[addr] = data;
  endtask

  // Run with en held for the entry edge plus n RUN edges, then watch drain.
  task automatic runScenario(input string tag, input logic [31:0] fw, input logic [31:0] pw,
                             input int n, input bit hold_lv);
    int          got;
    logic [31:0] last;
    got   = 0;
    last  = dout;
    fword = fw;
    pword = pw;
    en    = 1'b1;
    load_valid = 1'b0;
    for (int j = 0; j <= n + 4; j++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_valid"}, 64'(dout_valid), 64'((j >= 2) && (j <= n + 1)));
      if ((j >= 2) && (j <= n + 1)) begin
        last = modelSample(j - 2, fw, pw);
        checkOutput({tag, "_dout"}, 64'(dout), 64'(last));
      end
      checkOutput({tag, "_busy"}, 64'(busy), 64'(j <= n + 2));
      checkOutput({tag, "_ready"}, 64'(load_ready), 64'(j > n + 2));
      if (dout_valid) got++;
      if (j == n) en = 1'b0;
      if (hold_lv && j == 0) begin
        load_valid = 1'b1;
        load_addr  = 10'd7;
        load_data  = 32'hDEADBEEF;
      end
      if (hold_lv && j == n + 4) begin
        load_valid = 1'b0;
        model_tbl[7] = 32'hDEADBEEF;
      end
    end
    checkOutput({tag, "_count"}, 64'(got), 64'(n));
    checkOutput({tag, "_hold"}, 64'(dout), 64'(last));
  endtask

  // Directed scenarios followed by randomized runs.
  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    en    = 1'b0;
    fword = '0;
    pword = '0;

    #12;
    checkOutput("rst_valid", 64'(dout_valid), 64'd0);
    checkOutput("rst_dout", 64'(dout), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ready", 64'(load_ready), 64'd1);

    $display("[TB] loading square table");
    for (int i = 0; i < 1024; i++) applyStimulus(10'(i), 32'(i * i));

    runScenario("sq", 32'd1 << 22, 32'd0, 16, 1'b0);
    runScenario("step3", 32'd3 << 22, 32'd5 << 22, 5, 1'b0);
    runScenario("wrap", 32'd1 << 22, 32'd1022 << 22, 4, 1'b0);

    $display("[TB] load_valid held through run");
    runScenario("lvhold", 32'd1 << 22, 32'd100 << 22, 3, 1'b1);
    runScenario("rd7", 32'd0, 32'd7 << 22, 2, 1'b0);

    $display("[TB] write and en in same IDLE cycle");
    en = 1'b1;
    load_valid = 1'b1;
    load_addr  = 10'd20;
    load_data  = $urandom;
    @(posedge clk); #1;
    checkOutput("wr_en_busy", 64'(busy), 64'd0);
    model_tbl[20] = load_data;
    runScenario("wr_en", 32'd1 << 22, 32'd20 << 22, 3, 1'b0);

    $display("[TB] async reset mid-run");
    fword = 32'd1 << 22;
    pword = 32'd0;
    en    = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_valid", 64'(dout_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(dout_valid), 64'd0);
    checkOutput("midrst_dout", 64'(dout), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("postrst_ready", 64'(load_ready), 64'd1);
    @(posedge clk); #1;
    runScenario("rerun", 32'd1 << 22, 32'd0, 16, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 4; r++) applyStimulus(10'($urandom_range(0, 1023)), $urandom);
    for (int r = 0; r < 4; r++) begin
      runScenario("rand", $urandom, $urandom, int'($urandom_range(1, 12)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
